// File: rtl/monolith_chunk_dispatch_mif.sv
// rtl/monolith_chunk_dispatch_mif.sv - chunk dispatcher: sink FIFO -> Monolith core -> AXIS master
//
// Pops one FIFO_CHUNK_SIZE-word chunk from the sink FIFO and hands it to the
// permutation core. It then streams the RESULT_WORDS-word result as AXI4-Stream
// beats, with TLAST on the last word of every PACKET_CHUNKS-th result.
//
// Ports:
//   M_AXIS_ACLK, M_AXIS_ARESET       clock, asynchronous active-high reset
//   fifo_out, fifo_empty             registered head chunk and its empty flag
//   fifo_read_strobe                 one-cycle pop of the head chunk
//   core_start, core_state           start pulse and captured chunk for the core
//   core_done, core_result           completion pulse and result words
//   M_AXIS_T*                        AXI4-Stream master towards the DMA
//   busy                             high whenever the FSM is not idle
module monolith_chunk_dispatch_mif #(
   parameter int FIFO_CHUNK_SIZE      = 16,
   parameter int RESULT_WORDS         = 8,
   parameter int PACKET_CHUNKS        = 4,
   parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
   input  logic                                                  M_AXIS_ACLK,
   input  logic                                                  M_AXIS_ARESET,
   input  logic [FIFO_CHUNK_SIZE-1:0][C_M_AXIS_TDATA_WIDTH-1:0] fifo_out,
   input  logic                                                  fifo_empty,
   output logic                                                  fifo_read_strobe,
   output logic                                                  core_start,
   output logic [FIFO_CHUNK_SIZE-1:0][C_M_AXIS_TDATA_WIDTH-1:0] core_state,
   input  logic                                                  core_done,
   input  logic [RESULT_WORDS-1:0][C_M_AXIS_TDATA_WIDTH-1:0]    core_result,
   output logic                                                  M_AXIS_TVALID,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]                       M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                     M_AXIS_TSTRB,
   output logic                                                  M_AXIS_TLAST,
   input  logic                                                  M_AXIS_TREADY,
   output logic                                                  busy
);

   // A parameter of 1 still gets a 1-bit counter; its last value is 0, so it
   // wraps on every step and stays constant 0.
   localparam int IDX_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;
   localparam int CNT_W = (PACKET_CHUNKS > 1) ? $clog2(PACKET_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESULT_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_CHUNKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_START,
      S_WAIT,
      S_STREAM
   } state_t;

   state_t                                                state_q, state_d;
   logic [FIFO_CHUNK_SIZE-1:0][C_M_AXIS_TDATA_WIDTH-1:0] core_state_q, core_state_d;
   logic [RESULT_WORDS-1:0][C_M_AXIS_TDATA_WIDTH-1:0]    result_q, result_d;
   logic [IDX_W-1:0]                                      word_idx_q, word_idx_d;
   logic [CNT_W-1:0]                                      chunk_cnt_q, chunk_cnt_d;

   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         state_q      <= S_IDLE;
         core_state_q <= '0;
         result_q     <= '0;
         word_idx_q   <= '0;
         chunk_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         core_state_q <= core_state_d;
         result_q     <= result_d;
         word_idx_q   <= word_idx_d;
         chunk_cnt_q  <= chunk_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      core_state_d     = core_state_q;
      result_d         = result_q;
      word_idx_d       = word_idx_q;
      chunk_cnt_d      = chunk_cnt_q;
      fifo_read_strobe = 1'b0;
      core_start       = 1'b0;
      M_AXIS_TVALID    = 1'b0;
      M_AXIS_TLAST     = 1'b0;
      M_AXIS_TDATA     = '0;

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) state_d = S_SETTLE;
         end
         // fifo_out is registered upstream and lags fifo_empty by one cycle.
         S_SETTLE: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            core_state_d     = fifo_out;
            fifo_read_strobe = 1'b1;
            state_d          = S_START;
         end
         S_START: begin
            core_start = 1'b1;
            state_d    = S_WAIT;
         end
         // core_done is only honoured here; the core never finishes in START.
         S_WAIT: begin
            if (core_done) begin
               result_d   = core_result;
               word_idx_d = '0;
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TDATA  = result_q[word_idx_q];
            M_AXIS_TLAST  = (word_idx_q == IDX_LAST) && (chunk_cnt_q == CNT_LAST);
            if (M_AXIS_TREADY) begin
               if (word_idx_q == IDX_LAST) begin
                  word_idx_d  = '0;
                  chunk_cnt_d = (chunk_cnt_q == CNT_LAST) ? '0 : chunk_cnt_q + CNT_W'(1);
                  state_d     = S_IDLE;
               end else begin
                  word_idx_d = word_idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign core_state   = core_state_q;
   assign M_AXIS_TSTRB = '1;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_monolith_chunk_dispatch_mif.sv
// tb/tb_monolith_chunk_dispatch_mif.sv - directed self-checking bench for monolith_chunk_dispatch_mif
module tb_monolith_chunk_dispatch_mif;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [15:0][31:0] fifo_out;
   logic              fifo_empty;
   logic              fifo_read_strobe;
   logic              core_start;
   logic [15:0][31:0] core_state;
   logic              core_done;
   logic [7:0][31:0]  core_result;
   logic              tvalid;
   logic [31:0]       tdata;
   logic [3:0]        tstrb;
   logic              tlast;
   logic              tready;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // observations of the most recent do_chunk run
   int          obs_strobe_cyc, obs_start_cyc, obs_done_cyc;
   int          obs_strobes, obs_starts, obs_state_bad, obs_stall_bad, obs_beats;
   logic [31:0] obs_data [8];
   logic        obs_last [8];

   always #5 clk = ~clk;

   monolith_chunk_dispatch_mif dut (
      .M_AXIS_ACLK      (clk),
      .M_AXIS_ARESET    (rst),
      .fifo_out         (fifo_out),
      .fifo_empty       (fifo_empty),
      .fifo_read_strobe (fifo_read_strobe),
      .core_start       (core_start),
      .core_state       (core_state),
      .core_done        (core_done),
      .core_result      (core_result),
      .M_AXIS_TVALID    (tvalid),
      .M_AXIS_TDATA     (tdata),
      .M_AXIS_TSTRB     (tstrb),
      .M_AXIS_TLAST     (tlast),
      .M_AXIS_TREADY    (tready),
      .busy             (busy)
   );

   // Offers one chunk (words base+i) to the DUT, models the core (done pulse
   // lat cycles after core_start, result rbase+i) and collects the AXIS beats.
   // Cycle 0 is the negedge at which fifo_empty falls. bp selects the
   // 1,0,0,1 TREADY pattern. Results are left in the obs_* variables.
   task automatic do_chunk(input logic [31:0] base, input logic [31:0] rbase,
                           input int lat, input bit bp);
      int          cyc, scnt;
      bit          done_sent, pv, pr, pl;
      logic [31:0] pd;
      obs_strobe_cyc = -1; obs_start_cyc = -1; obs_done_cyc = -1;
      obs_strobes = 0; obs_starts = 0; obs_state_bad = 0; obs_stall_bad = 0; obs_beats = 0;
      for (int i = 0; i < 16; i++) fifo_out[i] = base + 32'(i);
      for (int i = 0; i < 8; i++) core_result[i] = rbase + 32'(i);
      fifo_empty = 1'b0;
      cyc = 0; scnt = 0; done_sent = 0; pv = 0; pr = 0; pl = 0; pd = '0;
      while (obs_beats < 8 && cyc < 600) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         core_done = 1'b0;
         if (fifo_read_strobe) begin
            obs_strobes++;
            if (obs_strobe_cyc < 0) obs_strobe_cyc = cyc;
            fifo_empty = 1'b1;
         end
         if (core_start) begin
            obs_starts++;
            if (obs_start_cyc < 0) obs_start_cyc = cyc;
         end
         if (obs_start_cyc >= 0 && !done_sent) begin
            for (int i = 0; i < 16; i++)
               if (core_state[i] !== base + 32'(i)) obs_state_bad++;
            if (cyc == obs_start_cyc + lat) begin
               core_done    = 1'b1;
               done_sent    = 1;
               obs_done_cyc = cyc;
            end
         end
         if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl)) obs_stall_bad++;
         pv = tvalid; pd = tdata; pl = tlast;
         pr = bp ? ((scnt % 4 == 0) || (scnt % 4 == 3)) : 1'b1;
         if (tvalid) scnt++;
         tready = pr;
         if (tvalid && pr) begin
            obs_data[obs_beats] = tdata;
            obs_last[obs_beats] = tlast;
            obs_beats++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      core_done = 1'b0;
      tready    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_empty = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (fifo_read_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", fifo_read_strobe); end
      checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", core_start); end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
      checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
      checks++; if (core_state !== '0) begin errors++; $display("FAIL reset_core_state got %h want 0", core_state); end
      checks++; if (tstrb !== 4'hF) begin errors++; $display("FAIL reset_tstrb got %h want f", tstrb); end
      fifo_empty = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_chunk();
      do_chunk(32'h0, 32'hA0, 7, 0);
      checks++; if (obs_beats != 8) begin errors++; $display("FAIL single_beats got %0d want 8", obs_beats); end
      checks++; if (obs_strobe_cyc != 2) begin errors++; $display("FAIL single_strobe_cyc got %0d want 2", obs_strobe_cyc); end
      checks++; if (obs_start_cyc != 3) begin errors++; $display("FAIL single_start_cyc got %0d want 3", obs_start_cyc); end
      checks++; if (obs_done_cyc != 10) begin errors++; $display("FAIL single_done_cyc got %0d want 10", obs_done_cyc); end
      checks++; if (obs_state_bad != 0) begin errors++; $display("FAIL single_core_state bad words %0d want 0", obs_state_bad); end
      checks++; if (obs_strobes != 1 || obs_starts != 1) begin errors++; $display("FAIL single_pops got %0d/%0d want 1/1", obs_strobes, obs_starts); end
      for (int b = 0; b < obs_beats; b++) begin
         checks++; if (obs_data[b] !== 32'hA0 + 32'(b)) begin errors++; $display("FAIL single_data[%0d] got %h want %h", b, obs_data[b], 32'hA0 + 32'(b)); end
         checks++; if (obs_last[b] !== 1'b0) begin errors++; $display("FAIL single_tlast[%0d] got %b want 0", b, obs_last[b]); end
      end
      checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after got tvalid=%b busy=%b want 0/0", tvalid, busy); end
   endtask

   task automatic test_backpressure();
      do_chunk(32'h100, 32'hB0, 3, 1);
      checks++; if (obs_beats != 8) begin errors++; $display("FAIL bp_beats got %0d want 8", obs_beats); end
      checks++; if (obs_stall_bad != 0) begin errors++; $display("FAIL bp_stall_stability got %0d violations want 0", obs_stall_bad); end
      for (int b = 0; b < obs_beats; b++) begin
         checks++; if (obs_data[b] !== 32'hB0 + 32'(b)) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", b, obs_data[b], 32'hB0 + 32'(b)); end
         checks++; if (obs_last[b] !== 1'b0) begin errors++; $display("FAIL bp_tlast[%0d] got %b want 0", b, obs_last[b]); end
      end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got tvalid=%b want 0", tvalid); end
   endtask

   task automatic test_empty_fifo();
      int n_strobe = 0, n_start = 0, n_valid = 0, n_busy = 0;
      fifo_empty = 1'b1;
      tready = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (fifo_read_strobe) n_strobe++;
         if (core_start) n_start++;
         if (tvalid) n_valid++;
         if (busy) n_busy++;
      end
      tready = 1'b0;
      checks++; if (n_strobe != 0) begin errors++; $display("FAIL empty_strobe got %0d cycles want 0", n_strobe); end
      checks++; if (n_start != 0) begin errors++; $display("FAIL empty_start got %0d cycles want 0", n_start); end
      checks++; if (n_valid != 0) begin errors++; $display("FAIL empty_tvalid got %0d cycles want 0", n_valid); end
      checks++; if (n_busy != 0) begin errors++; $display("FAIL empty_busy got %0d cycles want 0", n_busy); end
   endtask

   task automatic test_core_latency();
      int lats [2] = '{1, 50};
      for (int k = 0; k < 2; k++) begin
         do_chunk(32'h200 + 32'(k * 16), 32'hC0 + 32'(k * 16), lats[k], 0);
         checks++; if (obs_beats != 8) begin errors++; $display("FAIL lat%0d_beats got %0d want 8", lats[k], obs_beats); end
         checks++; if (obs_done_cyc != 3 + lats[k]) begin errors++; $display("FAIL lat%0d_done_cyc got %0d want %0d", lats[k], obs_done_cyc, 3 + lats[k]); end
         checks++; if (obs_state_bad != 0) begin errors++; $display("FAIL lat%0d_core_state bad words %0d want 0", lats[k], obs_state_bad); end
         checks++; if (obs_strobes != 1 || obs_starts != 1) begin errors++; $display("FAIL lat%0d_pops got %0d/%0d want 1/1", lats[k], obs_strobes, obs_starts); end
         checks++; if (obs_data[0] !== 32'hC0 + 32'(k * 16) || obs_data[7] !== 32'hC7 + 32'(k * 16)) begin
            errors++; $display("FAIL lat%0d_data got %h..%h want %h..%h", lats[k], obs_data[0], obs_data[7], 32'hC0 + 32'(k * 16), 32'hC7 + 32'(k * 16));
         end
      end
   endtask

   // Four chunks precede this (chunk_cnt back at 0), so chunk 3 closes a packet.
   task automatic test_packetisation();
      for (int c = 0; c < 5; c++) begin
         do_chunk(32'h1000 + 32'(c * 16), 32'h2000 + 32'(c * 8), 2, 0);
         checks++; if (obs_beats != 8) begin errors++; $display("FAIL pkt_beats[%0d] got %0d want 8", c, obs_beats); end
         for (int b = 0; b < obs_beats; b++) begin
            checks++; if (obs_last[b] !== ((c == 3) && (b == 7))) begin
               errors++; $display("FAIL pkt_tlast[%0d][%0d] got %b want %b", c, b, obs_last[b], (c == 3) && (b == 7));
            end
            checks++; if (obs_data[b] !== 32'h2000 + 32'(c * 8 + b)) begin
               errors++; $display("FAIL pkt_data[%0d][%0d] got %h want %h", c, b, obs_data[b], 32'h2000 + 32'(c * 8 + b));
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      int nb = 0, cyc = 0;
      bit got_reset = 0, pend = 0;
      for (int i = 0; i < 16; i++) fifo_out[i] = 32'h400 + 32'(i);
      for (int i = 0; i < 8; i++) core_result[i] = 32'hE0 + 32'(i);
      fifo_empty = 1'b0;
      tready = 1'b1;
      while (!got_reset && cyc < 200) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         core_done = 1'b0;
         if (fifo_read_strobe) fifo_empty = 1'b1;
         if (pend) begin core_done = 1'b1; pend = 0; end
         if (core_start) pend = 1;
         if (tvalid) begin
            if (nb == 3) begin
               rst = 1'b1;
               #1;
               got_reset = 1;
            end else begin
               nb++;
            end
         end
      end
      checks++; if (!got_reset) begin errors++; $display("FAIL rstmid_reach_beat3 got beats=%0d want 3", nb); end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", tvalid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
      checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL rstmid_tdata got %h want 0", tdata); end
      checks++; if (core_state !== '0) begin errors++; $display("FAIL rstmid_core_state got %h want 0", core_state); end
      @(negedge clk);
      rst = 1'b0;
      core_done = 1'b0;
      tready = 1'b0;
      @(negedge clk);
      // chunk_cnt was 1 before the reset; only a cleared count puts TLAST on chunk 3
      for (int c = 0; c < 4; c++) begin
         do_chunk(32'h500 + 32'(c * 16), 32'h3000 + 32'(c * 8), 2, 0);
         checks++; if (obs_beats != 8) begin errors++; $display("FAIL rstmid_beats[%0d] got %0d want 8", c, obs_beats); end
         for (int b = 0; b < obs_beats; b++) begin
            checks++; if (obs_last[b] !== ((c == 3) && (b == 7))) begin
               errors++; $display("FAIL rstmid_tlast[%0d][%0d] got %b want %b", c, b, obs_last[b], (c == 3) && (b == 7));
            end
         end
      end
   endtask

   initial begin
      fifo_out    = '0;
      fifo_empty  = 1'b1;
      core_done   = 1'b0;
      core_result = '0;
      tready      = 1'b0;
      test_reset();
      test_single_chunk();
      test_backpressure();
      test_empty_fifo();
      test_core_latency();
      test_packetisation();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
